chacha_block_ctrl: RTL and testbench
====================================

CHACHA_BLOCK_CTRL -- requirements
Module: chacha_block_ctrl

Interface
REQ-001 SHALL have parameter NUM_DOUBLE_ROUNDS, default 10: number of column+diagonal round pairs per block.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: request a run of num_blocks keystream blocks; sampled only in IDLE.
REQ-005 SHALL have port init_counter, input, 32: block counter value for the first block; captured on start.
REQ-006 SHALL have port num_blocks, input, 16: number of blocks in the run; captured on start.
REQ-007 SHALL have port abort, input, 1: synchronous cancel of the current run.
REQ-008 SHALL have port clr_matrix, output, 1: clears the state-matrix builder.
REQ-009 SHALL have port load_state, output, 1: one-cycle pulse that loads constants, key, nonce and block into the working state.
REQ-010 SHALL have port block, output, 32: current block counter value driven to the state-matrix builder.
REQ-011 SHALL have port qr_start, output, 1: one-cycle pulse that starts four parallel quarter-rounds.
REQ-012 SHALL have port qr_diag, output, 1: 0 = column round, 1 = diagonal round; stable from qr_start until qr_done.
REQ-013 SHALL have port qr_done, input, 1: quarter-round datapath finished the issued round.
REQ-014 SHALL have port add_en, output, 1: one-cycle pulse that adds the initial state to the working state.
REQ-015 SHALL have port ks_valid, output, 1: keystream block available downstream.
REQ-016 SHALL have port ks_ready, input, 1: downstream accepts the block.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse at the end of a run.
REQ-019 SHALL have port err_ovf, output, 1: sticky counter-overflow flag.

Function
REQ-020 SHALL implement the states IDLE, CLEAR, LOAD, ISSUE, WAIT, ADD and OUT.
REQ-021 IDLE, start=1, num_blocks>0: SHALL capture init_counter into block, capture num_blocks into remaining, clear err_ovf, and go to CLEAR.
REQ-022 IDLE, start=1, num_blocks=0: SHALL pulse done in the next cycle, stay in IDLE, and leave all other outputs unchanged.
REQ-023 CLEAR: SHALL assert clr_matrix for exactly 1 cycle and then go to LOAD.
REQ-024 LOAD: SHALL assert load_state for exactly 1 cycle, reset the half-round count hr to 0, and then go to ISSUE.
REQ-025 ISSUE: SHALL pulse qr_start for 1 cycle with qr_diag = hr[0], and then go to WAIT.
REQ-026 WAIT: SHALL sample qr_done starting the cycle after qr_start, and SHALL ignore qr_done in every other state.
REQ-027 WAIT, qr_done=1, hr < 2*NUM_DOUBLE_ROUNDS-1: SHALL increment hr and go to ISSUE.
REQ-028 WAIT, qr_done=1, hr = 2*NUM_DOUBLE_ROUNDS-1: SHALL go to ADD.
REQ-029 ADD: SHALL pulse add_en for 1 cycle and then go to OUT.
REQ-030 OUT: SHALL hold ks_valid=1 until the cycle with ks_ready=1; the transfer completes in that cycle.
REQ-031 OUT, transfer, remaining>1: SHALL decrement remaining, set block = block+1, and go to LOAD without passing through CLEAR.
REQ-032 OUT, transfer, remaining=1: SHALL pulse done and go to IDLE.
REQ-033 OUT, transfer, remaining>1, block=32'hFFFFFFFF: SHALL NOT wrap; SHALL set err_ovf, pulse done, and go to IDLE.
REQ-034 abort=1 in any non-IDLE state: SHALL go to CLEAR, then IDLE, with no done pulse; abort has priority over every other transition.
REQ-035 abort=1 in IDLE: SHALL have no effect.
REQ-036 start outside IDLE: SHALL be ignored.
REQ-037 Per-block latency from LOAD entry to ks_valid, with qr_done returned k cycles after each qr_start, SHALL be 1 + 2*NUM_DOUBLE_ROUNDS*(1+k) + 1 cycles.
REQ-038 All control outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-039 rst_n=0 SHALL immediately force IDLE, block=0, remaining=0, hr=0, and every 1-bit output = 0.
REQ-040 rst_n=0 mid-run SHALL discard the run; after release the block SHALL accept start normally.

Verification
REQ-041 start, init_counter=1, num_blocks=1, qr_done k=1 -> clr 1 cycle, load 1 cycle, 20 qr_start pulses with qr_diag 0,1,0,1..., add_en, ks_valid 42 cycles after LOAD, done, block=1.
REQ-042 num_blocks=3, init_counter=7, ks_ready held low 5 cycles per block -> ks_valid holds each time, block values 7, 8, 9, exactly 3 transfers, one done.
REQ-043 init_counter=32'hFFFFFFFE, num_blocks=4 -> blocks FFFFFFFE and FFFFFFFF delivered, then err_ovf=1, done, IDLE; no third load_state.
REQ-044 abort during the 5th WAIT, with qr_done asserted in the same cycle -> CLEAR then IDLE, no done, no further qr_start.
REQ-045 start with num_blocks=0 -> done next cycle, busy stays 0; qr_done pulsed in IDLE -> no state change.
REQ-046 rst_n low in OUT with ks_valid=1 -> all outputs 0 asynchronously; after release, a new start runs REQ-041 correctly.

Source files
------------

// File: rtl/chacha_block_ctrl.sv
// ChaCha keystream block controller.
// Sequences one or more keystream blocks. For each block it loads the state matrix,
// issues 2*NUM_DOUBLE_ROUNDS half-rounds (alternating column/diagonal) to an external
// quarter-round datapath, adds the initial state back, and presents the block downstream.
// Every control output is a flop fed from next-state logic, so no input reaches an output
// combinationally.
module chacha_block_ctrl #(
  parameter int unsigned NUM_DOUBLE_ROUNDS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] init_counter,
  input  logic [15:0] num_blocks,
  input  logic        abort,
  output logic        clr_matrix,
  output logic        load_state,
  output logic [31:0] block,
  output logic        qr_start,
  output logic        qr_diag,
  input  logic        qr_done,
  output logic        add_en,
  output logic        ks_valid,
  input  logic        ks_ready,
  output logic        busy,
  output logic        done,
  output logic        err_ovf
);

  // Index of the last half-round in a block. NUM_DOUBLE_ROUNDS must be at least 1.
  localparam int unsigned HrLast = 2 * NUM_DOUBLE_ROUNDS - 1;
  localparam int unsigned HrW    = (HrLast > 0) ? $clog2(HrLast + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StIssue,
    StWait,
    StAdd,
    StOut
  } state_e;

  state_e           state_q, state_d;
  logic             aborting_q, aborting_d;
  logic [31:0]      block_q, block_d;
  logic [15:0]      remaining_q, remaining_d;
  logic [HrW-1:0]   hr_q, hr_d;
  logic             err_ovf_q, err_ovf_d;
  logic             done_q, done_d;
  logic             qr_diag_q, qr_diag_d;
  logic             clr_q, clr_d;
  logic             load_q, load_d;
  logic             qr_start_q, qr_start_d;
  logic             add_q, add_d;
  logic             ks_valid_q, ks_valid_d;
  logic             busy_q, busy_d;

  // Next-state, datapath-register and registered-output decode.
  always_comb begin
    state_d     = state_q;
    aborting_d  = aborting_q;
    block_d     = block_q;
    remaining_d = remaining_q;
    hr_d        = hr_q;
    err_ovf_d   = err_ovf_q;
    done_d      = 1'b0;

    if (abort && (state_q != StIdle)) begin
      // Abort wins over everything; a single CLEAR scrubs the matrix before idling.
      state_d    = StClear;
      aborting_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (num_blocks != 16'd0) begin
              block_d     = init_counter;
              remaining_d = num_blocks;
              err_ovf_d   = 1'b0;
              aborting_d  = 1'b0;
              state_d     = StClear;
            end else begin
              // Empty run: acknowledge only, leave everything else alone.
              done_d = 1'b1;
            end
          end
        end
        StClear: begin
          state_d    = aborting_q ? StIdle : StLoad;
          aborting_d = 1'b0;
        end
        StLoad: begin
          hr_d    = '0;
          state_d = StIssue;
        end
        StIssue: begin
          state_d = StWait;
        end
        StWait: begin
          if (qr_done) begin
            if (hr_q == HrW'(HrLast)) begin
              state_d = StAdd;
            end else begin
              hr_d    = hr_q + HrW'(1);
              state_d = StIssue;
            end
          end
        end
        StAdd: begin
          state_d = StOut;
        end
        StOut: begin
          if (ks_ready) begin
            if (remaining_q > 16'd1) begin
              if (block_q == 32'hFFFF_FFFF) begin
                // Counter would wrap and reuse keystream: stop the run and flag it.
                err_ovf_d = 1'b1;
                done_d    = 1'b1;
                state_d   = StIdle;
              end else begin
                remaining_d = remaining_q - 16'd1;
                block_d     = block_q + 32'd1;
                state_d     = StLoad;
              end
            end else begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Diagonal select is latched on entry to ISSUE and held through the wait.
    qr_diag_d  = (state_d == StIssue) ? hr_d[0] : qr_diag_q;

    clr_d      = (state_d == StClear);
    load_d     = (state_d == StLoad);
    qr_start_d = (state_d == StIssue);
    add_d      = (state_d == StAdd);
    ks_valid_d = (state_d == StOut);
    busy_d     = (state_d != StIdle);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      aborting_q  <= 1'b0;
      block_q     <= 32'd0;
      remaining_q <= 16'd0;
      hr_q        <= '0;
      err_ovf_q   <= 1'b0;
      done_q      <= 1'b0;
      qr_diag_q   <= 1'b0;
      clr_q       <= 1'b0;
      load_q      <= 1'b0;
      qr_start_q  <= 1'b0;
      add_q       <= 1'b0;
      ks_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      aborting_q  <= aborting_d;
      block_q     <= block_d;
      remaining_q <= remaining_d;
      hr_q        <= hr_d;
      err_ovf_q   <= err_ovf_d;
      done_q      <= done_d;
      qr_diag_q   <= qr_diag_d;
      clr_q       <= clr_d;
      load_q      <= load_d;
      qr_start_q  <= qr_start_d;
      add_q       <= add_d;
      ks_valid_q  <= ks_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign clr_matrix = clr_q;
  assign load_state = load_q;
  assign block      = block_q;
  assign qr_start   = qr_start_q;
  assign qr_diag    = qr_diag_q;
  assign add_en     = add_q;
  assign ks_valid   = ks_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_chacha_block_ctrl.sv
// Bench for chacha_block_ctrl: table of runs checked against a block-counter scoreboard,
// plus hand sequences for empty runs, abort, and reset in OUT.
`timescale 1ns/1ps
module tb_chacha_block_ctrl;
  localparam int unsigned NDR = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] init_counter;
  logic [15:0] num_blocks;
  logic        abort;
  logic        clr_matrix;
  logic        load_state;
  logic [31:0] block;
  logic        qr_start;
  logic        qr_diag;
  logic        qr_done;
  logic        add_en;
  logic        ks_valid;
  logic        ks_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        err_ovf;

  logic        qr_done_resp = 1'b0;
  logic        qr_force = 1'b0;
  assign qr_done = qr_done_resp | qr_force;

  always #5 clk = ~clk;

  chacha_block_ctrl #(.NUM_DOUBLE_ROUNDS(NDR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .init_counter (init_counter),
    .num_blocks   (num_blocks),
    .abort        (abort),
    .clr_matrix   (clr_matrix),
    .load_state   (load_state),
    .block        (block),
    .qr_start     (qr_start),
    .qr_diag      (qr_diag),
    .qr_done      (qr_done),
    .add_en       (add_en),
    .ks_valid     (ks_valid),
    .ks_ready     (ks_ready),
    .busy         (busy),
    .done         (done),
    .err_ovf      (err_ovf)
  );

  int errors = 0;
  int checks = 0;

  // Environment knobs set by the main sequence.
  int k_lat = 1;
  int stall = 0;

  // Scoreboard of expected block counter values, one per transfer.
  logic [31:0] sb[$];

  int done_cnt = 0, xfer_cnt = 0, load_cnt = 0, qs_cnt = 0;
  int cyc = 0, load_cyc = 0, pend = 0, stall_cnt = 0, qr_idx = 0;
  bit wait_valid = 1'b0, prev_pending = 1'b0;
  logic held_diag = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Quarter-round responder, downstream sink and protocol monitor, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend = 0; qr_done_resp = 1'b0; ks_ready = 1'b0; stall_cnt = 0;
      wait_valid = 1'b0; prev_pending = 1'b0;
    end else begin
      qr_done_resp = 1'b0;
      if (pend > 0) begin
        check("qr_diag_stable", 32'(qr_diag), 32'(held_diag));
        pend--;
        if (pend == 0) qr_done_resp = 1'b1;
      end
      if (qr_start) begin
        check("qr_diag_parity", 32'(qr_diag), 32'(qr_idx % 2));
        qr_idx++; qs_cnt++; held_diag = qr_diag; pend = k_lat;
      end
      if (load_state) begin
        load_cnt++; load_cyc = cyc; wait_valid = 1'b1; qr_idx = 0;
      end
      if (add_en) check("qr_count", 32'(qr_idx), 2 * NDR);
      if (ks_valid && wait_valid) begin
        check("latency", 32'(cyc - load_cyc), 32'(2 + 2 * NDR * (1 + k_lat)));
        wait_valid = 1'b0;
      end
      if (prev_pending) check("ks_valid_hold", 32'(ks_valid), 32'd1);
      if (ks_valid) begin
        if (stall_cnt < stall) begin
          ks_ready = 1'b0; stall_cnt++;
        end else begin
          ks_ready = 1'b1;
        end
      end else begin
        ks_ready = 1'b0;
      end
      prev_pending = ks_valid && !ks_ready;
      if (ks_valid && ks_ready) begin
        xfer_cnt++; stall_cnt = 0;
        if (sb.size() != 0) check("xfer_block", block, sb.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  typedef struct {
    logic [31:0] init;
    logic [15:0] nb;
    int          stall;
    int          k;
    int          exp_xfers;
    logic        exp_ovf;
    logic [31:0] exp_block;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] b;
    int nb_i;
    int n;
    k_lat = v.k;
    stall = v.stall;
    sb.delete();
    b = v.init;
    nb_i = int'(v.nb);
    for (int i = 0; i < nb_i; i++) begin
      sb.push_back(b);
      if (i < nb_i - 1) begin
        if (b == 32'hFFFF_FFFF) break;
        b = b + 32'd1;
      end
    end
    done_cnt = 0; xfer_cnt = 0; load_cnt = 0;
    @(negedge clk);
    start = 1'b1; init_counter = v.init; num_blocks = v.nb;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_clr"}, 32'(clr_matrix), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_clr_one"}, 32'(clr_matrix), 32'd0);
    check({tag, "_load"}, 32'(load_state), 32'd1);
    for (n = 0; n < 20000 && !done; n++) @(negedge clk);
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    @(negedge clk);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_xfers"}, 32'(xfer_cnt), 32'(v.exp_xfers));
    check({tag, "_loads"}, 32'(load_cnt), 32'(v.exp_xfers));
    check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    check({tag, "_err_ovf"}, 32'(err_ovf), 32'(v.exp_ovf));
    check({tag, "_block"}, block, v.exp_block);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int qs_local;
    int qs_before;
    vecs[0] = '{32'd1,          16'd1, 0, 1, 1, 1'b0, 32'd1};
    vecs[1] = '{32'd7,          16'd3, 5, 1, 3, 1'b0, 32'd9};
    vecs[2] = '{32'hFFFF_FFFE,  16'd4, 0, 2, 2, 1'b1, 32'hFFFF_FFFF};
    vecs[3] = '{32'd100,        16'd2, 1, 3, 2, 1'b0, 32'd101};
    vecs[4] = '{32'hFFFF_FFFF,  16'd1, 0, 1, 1, 1'b0, 32'hFFFF_FFFF};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; init_counter = '0; num_blocks = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ks_valid", 32'(ks_valid), 32'd0);
    check("rst_block", block, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_ovf", 32'(err_ovf), 32'd0);
    check("rst_clr", 32'(clr_matrix), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Empty run: done next cycle, nothing else moves.
    @(negedge clk);
    start = 1'b1; num_blocks = 16'd0; init_counter = 32'd123;
    @(negedge clk);
    start = 1'b0;
    check("nb0_done", 32'(done), 32'd1);
    check("nb0_busy", 32'(busy), 32'd0);
    check("nb0_block", block, vecs[4].exp_block);
    check("nb0_clr", 32'(clr_matrix), 32'd0);
    @(negedge clk);
    check("nb0_done_pulse", 32'(done), 32'd0);

    // Stray qr_done and abort while idle.
    qr_force = 1'b1; abort = 1'b1;
    @(negedge clk);
    qr_force = 1'b0; abort = 1'b0;
    check("idle_stray_busy", 32'(busy), 32'd0);
    check("idle_stray_qs", 32'(qr_start), 32'd0);
    @(negedge clk);
    check("idle_stray_busy2", 32'(busy), 32'd0);
    check("idle_stray_clr", 32'(clr_matrix), 32'd0);

    // Abort in the 5th WAIT, coinciding with qr_done.
    k_lat = 1; stall = 0; sb.delete();
    done_cnt = 0; load_cnt = 0;
    start = 1'b1; init_counter = 32'd5; num_blocks = 16'd2;
    @(negedge clk);
    start = 1'b0;
    qs_local = 0;
    for (n = 0; n < 2000 && qs_local < 5; n++) begin
      @(negedge clk);
      if (qr_start) qs_local++;
    end
    check("abort_reach_5th", 32'(qs_local), 32'd5);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    qs_before = qs_cnt;
    check("abort_clr", 32'(clr_matrix), 32'd1);
    check("abort_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_clr_one", 32'(clr_matrix), 32'd0);
    repeat (30) @(negedge clk);
    check("abort_no_qs", 32'(qs_cnt), 32'(qs_before));
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_loads", 32'(load_cnt), 32'd1);

    // Reset while a block waits in OUT.
    k_lat = 1; stall = 100000; sb.delete();
    start = 1'b1; init_counter = 32'd3; num_blocks = 16'd2;
    @(negedge clk);
    start = 1'b0;
    for (n = 0; n < 2000 && !ks_valid; n++) @(negedge clk);
    check("rstout_valid", 32'(ks_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstout_ks_valid", 32'(ks_valid), 32'd0);
    check("rstout_busy", 32'(busy), 32'd0);
    check("rstout_block", block, 32'd0);
    check("rstout_qs", 32'(qr_start), 32'd0);
    check("rstout_add", 32'(add_en), 32'd0);
    check("rstout_load", 32'(load_state), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 0;
    run_vec(vecs[0], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
